demux_router: RTL and testbench

- Registered 1-to-N demultiplexer with valid/ready handshake. It is the inverse of the datapath 2:1 select mux.
- Accepts one data beat plus a select index and steers the beat into one of NOUT per-channel output slots.
- Each slot holds exactly one entry until its consumer takes it.
- Sits between a single producer (ALU/write-back result) and several consumers (register-file write port, memory write stage, debug tap).

---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_slot.sv | 55 +++++
 rtl/demux_router.sv | 87 ++++++++
 tb/tb_demux_router.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the demux_router codebase slice.
//   WIDTH_DEF / NOUT_DEF : default beat width and channel count
//   ERR_SAT              : saturation limit of the optional bad-select counter
//   slot_state_e         : per-slot EMPTY/FULL state
//   selw_f()             : select-index width for a channel count (clog2, min 1)
package demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NOUT_DEF  = 2;
  localparam int ERR_SAT   = 255;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic int selw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output buffer for a single router channel.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture load_data on the next edge
//   load_data    : beat to capture
//   drain        : consumer takes the held entry this cycle
//   data, valid  : held entry and its presence flag
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | no entry held, data is stale
// FULL  | entry held in data until drained/replaced
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  slot_state_e state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state <= FULL;
            data  <= load_data;
          end
        end
        FULL: begin
          // A load in the drain cycle replaces the entry with no bubble.
          if (load) begin
            data <= load_data;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign valid = (state == FULL);

endmodule

// File: rtl/demux_router.sv
// demux_router: registered 1-to-NOUT demultiplexer with valid/ready handshake.
// Steers each accepted beat into the one-entry slot chosen by in_sel.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_data/in_sel/in_valid/in_ready : producer handshake
//   out_data  : channel i in bits [i*WIDTH +: WIDTH]
//   out_valid / out_ready : per-channel consumer handshake
//   err_count / err_pulse : bad-select counter and strobe, only when the
//                           DEMUX_SELCHK_EN macro is defined
// Out-of-range selects (NOUT not a power of two) are accepted and discarded.
module demux_router
  import demux_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NOUT  = NOUT_DEF,
  localparam int SELW  = selw_f(NOUT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ready
`ifdef DEMUX_SELCHK_EN
  ,
  output logic [7:0]            err_count,
  output logic                  err_pulse
`endif
);

  // Padded to every encodable select so indexing with in_sel is always legal;
  // the pad bits read as an empty, not-ready slot.
  localparam int NPAD = 1 << SELW;

  logic [NPAD-1:0] valid_pad;
  logic [NPAD-1:0] ready_pad;
  logic [31:0]     sel_ext;
  logic            in_range;
  logic            accept;
  logic [NOUT-1:0] load;
  logic [NOUT-1:0] drain;

  assign valid_pad = NPAD'(out_valid);
  assign ready_pad = NPAD'(out_ready);
  assign sel_ext   = 32'(in_sel);
  assign in_range  = (sel_ext < 32'(NOUT));

  assign in_ready = reset_n & (~in_range | ~valid_pad[in_sel] | ready_pad[in_sel]);
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < NOUT; i++) begin : g_slot
    assign load[i]  = accept & in_range & (sel_ext == 32'(i));
    assign drain[i] = out_valid[i] & out_ready[i];

    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load[i]),
      .load_data (in_data),
      .drain     (drain[i]),
      .data      (out_data[i*WIDTH +: WIDTH]),
      .valid     (out_valid[i])
    );
  end

`ifdef DEMUX_SELCHK_EN
  logic bad_beat;
  assign bad_beat = accept & ~in_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= bad_beat;
      if (bad_beat && (err_count != 8'(ERR_SAT))) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: randomized and directed stimulus,
// per-channel expected-beat queues filled on acceptance and drained by a
// negedge monitor that compares handshake, occupancy and data.
module tb_demux_router;

`ifdef DEMUX_SELCHK_EN
  localparam int NOUT = 3;
`else
  localparam int NOUT = 2;
`endif
  localparam int WIDTH = 8;
  localparam int SELW  = demux_pkg::selw_f(NOUT);
  localparam int MAXSEL = (1 << SELW) - 1;

  logic                  clk;
  logic                  rst_n;
  logic [WIDTH-1:0]      in_data;
  logic [SELW-1:0]       in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [NOUT*WIDTH-1:0] out_data;
  logic [NOUT-1:0]       out_valid;
  logic [NOUT-1:0]       out_ready;
`ifdef DEMUX_SELCHK_EN
  logic [7:0]            err_count;
  logic                  err_pulse;
  logic                  exp_pulse;
  int                    exp_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] q [NOUT][$];

  demux_router #(
    .WIDTH (WIDTH),
    .NOUT  (NOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_SELCHK_EN
    ,
    .err_count (err_count),
    .err_pulse (err_pulse)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a slot is a queue of depth <= 1 per channel.
  always @(negedge rst_n) begin
    for (int i = 0; i < NOUT; i++) q[i].delete();
`ifdef DEMUX_SELCHK_EN
    exp_pulse = 1'b0;
    exp_cnt   = 0;
`endif
  end

  // Acceptance: drains due this cycle were already popped by the monitor,
  // so an empty queue means the slot can take the beat.
  always @(posedge clk) begin
    int s;
    if (rst_n) begin
      s = int'(in_sel);
`ifdef DEMUX_SELCHK_EN
      exp_pulse = in_valid && (s >= NOUT);
      if (exp_pulse && exp_cnt < 255) exp_cnt++;
`endif
      if (in_valid && s < NOUT && q[s].size() == 0) q[s].push_back(in_data);
    end
  end

  // Monitor: compare DUT against model, pop entries the consumer takes.
  always @(negedge clk) begin
    logic [NOUT-1:0] ev;
    logic            er;
    int              s;
    for (int i = 0; i < NOUT; i++) ev[i] = (q[i].size() != 0);
    s = int'(in_sel);
    if (!rst_n)        er = 1'b0;
    else if (s >= NOUT) er = 1'b1;
    else               er = !ev[s] || out_ready[s];
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    for (int i = 0; i < NOUT; i++) begin
      if (ev[i]) begin
        chk($sformatf("out_data[%0d]", i), 32'(out_data[i*WIDTH +: WIDTH]), 32'(q[i][0]));
        if (out_ready[i] && rst_n) void'(q[i].pop_front());
      end
    end
`ifdef DEMUX_SELCHK_EN
    chk("err_pulse", 32'(err_pulse), 32'(exp_pulse));
    chk("err_count", 32'(err_count), 32'(exp_cnt));
`endif
  end

  task automatic step(input logic v, input int sel, input logic [WIDTH-1:0] d,
                      input logic [NOUT-1:0] r);
    in_valid  = v;
    in_sel    = SELW'(sel);
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 0, '0, '0);
    step(1'b0, 0, '0, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    do_reset();
    chk("reset out_data", 32'(out_data), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);

    // Load channel 1 and stall it for 5 cycles, probing both selects.
    step(1'b1, 1, 8'hA5, '0);
    for (int k = 0; k < 5; k++) step(1'b0, k % 2, 8'h00, '0);
    chk("ch1 held", 32'(out_data[WIDTH +: WIDTH]), 32'hA5);
    step(1'b0, 0, '0, NOUT'(2));

    // Channel 0 full, then drained and reloaded in the same cycle.
    step(1'b1, 0, 8'h11, '0);
    step(1'b1, 0, 8'h22, NOUT'(1));
    chk("no bubble valid", 32'(out_valid[0]), 32'h1);
    chk("no bubble data", 32'(out_data[0 +: WIDTH]), 32'h22);
    step(1'b0, 0, '0, NOUT'(1));

    // Alternating selects with all consumers ready.
    for (int k = 1; k <= 4; k++) step(1'b1, (k + 1) % 2, WIDTH'(k), '1);
    step(1'b0, 0, '0, '1);

    // Fill both slots then pulse reset between edges.
    step(1'b1, 0, 8'h5A, '0);
    step(1'b1, 1, 8'hC3, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'h0);
    chk("async reset in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 1)),
`ifdef DEMUX_SELCHK_EN
           int'($urandom_range(0, MAXSEL)),
`else
           int'($urandom_range(0, NOUT - 1)),
`endif
           WIDTH'($urandom), NOUT'($urandom));
    end
    step(1'b0, 0, '0, '1);
    step(1'b0, 0, '0, '1);

`ifdef DEMUX_SELCHK_EN
    // 300 consecutive out-of-range beats from a clean reset.
    do_reset();
    for (int k = 0; k < 300; k++) step(1'b1, 3, WIDTH'(k), '0);
    chk("sat err_count", 32'(err_count), 32'd255);
    chk("sat err_pulse", 32'(err_pulse), 32'h1);
    chk("bad sel out_valid", 32'(out_valid), 32'h0);
    step(1'b0, 0, '0, '0);
    chk("err_pulse clears", 32'(err_pulse), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
